// File: rtl/sn_count_if.sv
// Stochastic-number counter bus: length write, start, stream bits, result handshake.
// The master side drives the control and stream inputs and consumes the result.
interface sn_count_if;
  logic [31:0] DATA_IN;
  logic        LEN_WE;
  logic        START;
  logic        SN_IN_P;
  logic        SN_IN_N;
  logic        SN_EN;
  logic        BUSY;
  logic        RES_VALID;
  logic        RES_READY;
  logic [31:0] RES_OUT;

  modport master (
    output DATA_IN, LEN_WE, START,
    output SN_IN_P, SN_IN_N, RES_READY,
    input  SN_EN, BUSY, RES_VALID, RES_OUT
  );

  modport slave (
    input  DATA_IN, LEN_WE, START,
    input  SN_IN_P, SN_IN_N, RES_READY,
    output SN_EN, BUSY, RES_VALID, RES_OUT
  );
endinterface

// File: rtl/sn_count.sv
// Counts a stochastic bit stream of programmable length (unipolar or bipolar)
// and hands the total to a consumer over a valid/ready handshake.
module sn_count #(
  parameter bit MODE = 1'b0
) (
  input  logic     CLK,
  input  logic     RST,
  sn_count_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [30:0] len_q;
  logic [30:0] rem_q;
  logic [31:0] acc_q;
  logic [31:0] res_q;
  logic [31:0] delta;
  logic        en_d;
  logic        start_ok;
  logic        unused_ok;

  assign unused_ok = bus.DATA_IN[31];

  // len_q is the pre-write value, so a same-cycle LEN_WE cannot affect START
  assign start_ok = bus.START && (len_q != 31'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = RUN;
      RUN:   if (rem_q == 31'd1) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  if (bus.RES_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    delta = 32'd0;
    if (MODE == 1'b0) begin
      delta = {31'd0, bus.SN_IN_P};
    end else if (bus.SN_IN_P && !bus.SN_IN_N) begin
      delta = 32'd1;
    end else if (!bus.SN_IN_P && bus.SN_IN_N) begin
      delta = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      len_q <= 31'd0;
      rem_q <= 31'd0;
      acc_q <= 32'd0;
      res_q <= 32'd0;
      en_d  <= 1'b0;
    end else begin
      state <= state_nx;
      en_d  <= (state == RUN);
      if (bus.LEN_WE) len_q <= bus.DATA_IN[30:0];
      if (state == IDLE && start_ok) begin
        rem_q <= len_q;
        acc_q <= 32'd0;
      end else begin
        if (state == RUN) rem_q <= rem_q - 31'd1;
        if (en_d) acc_q <= acc_q + delta;
      end
      // the final sample arrives in DRAIN, so fold it in while latching
      if (state == DRAIN) res_q <= acc_q + delta;
    end
  end

  assign bus.SN_EN     = (state == RUN);
  assign bus.BUSY      = (state != IDLE);
  assign bus.RES_VALID = (state == DONE);
  assign bus.RES_OUT   = res_q;

endmodule

// File: tb/tb_sn_count.sv
// Self-checking bench for sn_count: unipolar and bipolar instances share stimulus
// and are compared against sums kept from the generated stream.
module tb_sn_count;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        len_we;
  logic        start;
  logic        p_bit;
  logic        n_bit;
  logic        ready;

  int vecs = 0;
  int errs = 0;

  sn_count_if u ();
  sn_count_if b ();

  assign u.DATA_IN   = data_in;
  assign u.LEN_WE    = len_we;
  assign u.START     = start;
  assign u.SN_IN_P   = p_bit;
  assign u.SN_IN_N   = n_bit;
  assign u.RES_READY = ready;
  assign b.DATA_IN   = data_in;
  assign b.LEN_WE    = len_we;
  assign b.START     = start;
  assign b.SN_IN_P   = p_bit;
  assign b.SN_IN_N   = n_bit;
  assign b.RES_READY = ready;

  sn_count #(.MODE(1'b0)) dut_u (.CLK(clk), .RST(rst), .bus(u));
  sn_count #(.MODE(1'b1)) dut_b (.CLK(clk), .RST(rst), .bus(b));

  always #5 clk = ~clk;

  localparam int LIMIT = 200;

  task automatic set_len(input logic [31:0] d);
    @(negedge clk);
    len_we  = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    len_we = 1'b0;
  endtask

  // Acts as the upstream generator and measures one conversion.
  // pat: 0 random, 1 all positive, 2 all negative, 3 six positive then negative
  task automatic run(
    input  int          pat,
    input  bit          we_start,
    input  logic [31:0] we_data,
    input  int          mid_cyc,
    input  logic [31:0] mid_data,
    output int          en_cnt,
    output int          lat,
    output logic [31:0] ru,
    output logic [31:0] rb,
    output logic [31:0] eu,
    output logic [31:0] eb
  );
    int  su;
    int  sb;
    int  k;
    bit  en;
    su = 0; sb = 0; k = 0;
    en_cnt = 0; lat = -1; ru = 'x; rb = 'x;
    @(negedge clk);
    start = 1'b1;
    if (we_start) begin
      len_we  = 1'b1;
      data_in = we_data;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    len_we = 1'b0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      if (cyc == mid_cyc) begin
        len_we  = 1'b1;
        data_in = mid_data;
      end
      @(negedge clk);
      en = u.SN_EN;
      if (en) en_cnt++;
      if (u.RES_VALID) begin
        lat = cyc;
        ru  = u.RES_OUT;
        rb  = b.RES_OUT;
        break;
      end
      @(posedge clk);
      #1;
      len_we = 1'b0;
      if (en) begin
        unique case (pat)
          1: begin p_bit = 1'b1; n_bit = 1'b0; end
          2: begin p_bit = 1'b0; n_bit = 1'b1; end
          3: begin p_bit = (k < 6); n_bit = (k >= 6); end
          default: begin
            p_bit = 1'($urandom);
            n_bit = 1'($urandom);
          end
        endcase
        k++;
        su += int'(p_bit);
        if (p_bit && !n_bit) sb += 1;
        else if (!p_bit && n_bit) sb -= 1;
      end
    end
    eu = 32'(su);
    eb = 32'(sb);
  endtask

  task automatic accept;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({u.SN_EN, u.BUSY, u.RES_VALID} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ctl_u got=%b want=000", {u.SN_EN, u.BUSY, u.RES_VALID});
    end
    vecs++;
    if ({b.SN_EN, b.BUSY, b.RES_VALID} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ctl_b got=%b want=000", {b.SN_EN, b.BUSY, b.RES_VALID});
    end
    vecs++;
    if (u.RES_OUT !== 32'd0 || b.RES_OUT !== 32'd0) begin
      errs++;
      $display("FAIL reset_res got=%h/%h want=0", u.RES_OUT, b.RES_OUT);
    end
    rst = 1'b0;
  endtask

  task automatic test_len_zero;
    set_len(32'h8000_0000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (u.BUSY !== 1'b0 || b.BUSY !== 1'b0 || u.SN_EN !== 1'b0) begin
        errs++;
        $display("FAIL len_zero busy got=%b%b want=00", u.BUSY, b.BUSY);
      end
    end
  endtask

  task automatic test_unipolar;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd16);
    run(1, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 16) begin errs++; $display("FAIL uni_en got=%0d want=16", en); end
    vecs++;
    if (lat !== 18) begin errs++; $display("FAIL uni_lat got=%0d want=18", lat); end
    vecs++;
    if (ru !== 32'd16) begin errs++; $display("FAIL uni_res got=%0d want=16", ru); end
    vecs++;
    if (rb !== 32'd16) begin errs++; $display("FAIL uni_res_b got=%0d want=16", rb); end
    accept();
  endtask

  task automatic test_bipolar;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd8);
    run(3, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (rb !== 32'd4) begin errs++; $display("FAIL bi_mix got=%h want=4", rb); end
    vecs++;
    if (ru !== 32'd6) begin errs++; $display("FAIL bi_mix_u got=%h want=6", ru); end
    accept();
    run(2, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (rb !== 32'hFFFF_FFF8) begin
      errs++; $display("FAIL bi_neg got=%h want=fffffff8", rb);
    end
    vecs++;
    if (ru !== 32'd0) begin errs++; $display("FAIL bi_neg_u got=%h want=0", ru); end
    accept();
  endtask

  task automatic test_len_one;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd1);
    run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 1) begin errs++; $display("FAIL one_en got=%0d want=1", en); end
    vecs++;
    if (lat !== 3) begin errs++; $display("FAIL one_lat got=%0d want=3", lat); end
    vecs++;
    if (ru !== eu || rb !== eb) begin
      errs++; $display("FAIL one_res got=%h/%h want=%h/%h", ru, rb, eu, eb);
    end
    accept();
  endtask

  task automatic test_random;
    int en; int lat; int len; logic [31:0] ru, rb, eu, eb;
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 40);
      set_len(32'(len));
      run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
      vecs++;
      if (en !== len || lat !== len + 2) begin
        errs++;
        $display("FAIL rnd_timing len=%0d got en=%0d lat=%0d", len, en, lat);
      end
      vecs++;
      if (ru !== eu) begin errs++; $display("FAIL rnd_uni got=%h want=%h", ru, eu); end
      vecs++;
      if (rb !== eb) begin errs++; $display("FAIL rnd_bi got=%h want=%h", rb, eb); end
      accept();
    end
  endtask

  task automatic test_handshake;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd6);
    run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (ru !== eu || rb !== eb) begin
      errs++; $display("FAIL hs_res got=%h/%h want=%h/%h", ru, rb, eu, eb);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start = (i == 2);
      @(negedge clk);
      vecs++;
      if (u.RES_VALID !== 1'b1 || u.RES_OUT !== eu || b.RES_OUT !== eb) begin
        errs++;
        $display("FAIL hs_hold i=%0d got v=%b %h/%h want %h/%h",
                 i, u.RES_VALID, u.RES_OUT, b.RES_OUT, eu, eb);
      end
    end
    start = 1'b0;
    accept();
    @(negedge clk);
    vecs++;
    if (u.RES_VALID !== 1'b0 || u.BUSY !== 1'b0) begin
      errs++; $display("FAIL hs_release got v=%b busy=%b want 0 0", u.RES_VALID, u.BUSY);
    end
    vecs++;
    if (u.RES_OUT !== eu || b.RES_OUT !== eb) begin
      errs++; $display("FAIL hs_keep got=%h/%h want=%h/%h", u.RES_OUT, b.RES_OUT, eu, eb);
    end
    @(negedge clk);
    vecs++;
    if (u.BUSY !== 1'b0) begin errs++; $display("FAIL hs_no_restart got busy=%b want 0", u.BUSY); end
  endtask

  task automatic test_ready_early;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd5);
    ready = 1'b1;
    run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (lat !== 7 || rb !== eb) begin
      errs++; $display("FAIL early_run got lat=%0d res=%h want lat=7 res=%h", lat, rb, eb);
    end
    @(negedge clk);
    vecs++;
    if (u.RES_VALID !== 1'b0 || b.BUSY !== 1'b0) begin
      errs++; $display("FAIL early_done_len got v=%b busy=%b want 0 0", u.RES_VALID, b.BUSY);
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int en; int lat; logic [31:0] ru, rb, eu, eb;
    set_len(32'd3);
    run(0, 1, 32'd5, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 3) begin errs++; $display("FAIL col_start_en got=%0d want=3", en); end
    accept();
    run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 5) begin errs++; $display("FAIL col_next_en got=%0d want=5", en); end
    accept();
    run(0, 0, 0, 2, 32'd7, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 5 || ru !== eu || rb !== eb) begin
      errs++; $display("FAIL col_mid got en=%0d res=%h/%h want 5 %h/%h", en, ru, rb, eu, eb);
    end
    accept();
    run(0, 0, 0, 0, 0, en, lat, ru, rb, eu, eb);
    vecs++;
    if (en !== 7) begin errs++; $display("FAIL col_mid_next got=%0d want=7", en); end
    accept();
  endtask

  task automatic test_rst_midrun;
    int seen;
    set_len(32'd10);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (u.SN_EN !== 1'b1) begin errs++; $display("FAIL rst_pre got sn_en=%b want 1", u.SN_EN); end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({u.SN_EN, u.BUSY, u.RES_VALID, b.SN_EN, b.BUSY, b.RES_VALID} !== 6'd0) begin
      errs++;
      $display("FAIL rst_abort got=%b want=000000",
               {u.SN_EN, u.BUSY, u.RES_VALID, b.SN_EN, b.BUSY, b.RES_VALID});
    end
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (u.RES_VALID || b.RES_VALID || u.BUSY) seen++;
    end
    vecs++;
    if (seen !== 0) begin errs++; $display("FAIL rst_no_result got=%0d want=0", seen); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    vecs++;
    if (u.BUSY !== 1'b0) begin errs++; $display("FAIL rst_len_cleared got busy=%b want 0", u.BUSY); end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 32'd0;
    len_we = 1'b0;
    start = 1'b0;
    p_bit = 1'b0;
    n_bit = 1'b0;
    ready = 1'b0;
    test_reset();
    test_len_zero();
    test_unipolar();
    test_bipolar();
    test_len_one();
    test_random();
    test_handshake();
    test_ready_early();
    test_back_to_back();
    test_rst_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sn_count.md
SN_COUNT -- requirements
Module: sn_count

Interface
REQ-001 SHALL have parameter MODE, default 1'b0; 0 = unipolar count, 1 = bipolar count.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port DATA_IN  input  32  bus write data; bits [30:0] are the stream length.
REQ-005 SHALL have port LEN_WE  input  1  stream-length register write strobe.
REQ-006 SHALL have port START  input  1  start-conversion pulse.
REQ-007 SHALL have port SN_IN_P  input  1  registered positive stochastic bit from the upstream generator.
REQ-008 SHALL have port SN_IN_N  input  1  registered negative stochastic bit; used only when MODE=1.
REQ-009 SHALL have port SN_EN  output  1  advance enable driven to the upstream generator EN.
REQ-010 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-011 SHALL have port RES_VALID  output  1  result valid.
REQ-012 SHALL have port RES_READY  input  1  result accepted by the consumer.
REQ-013 SHALL have port RES_OUT  output  32  accumulated count; signed two's complement when MODE=1.

Function
REQ-014 SHALL hold a 31-bit LEN register; LEN_WE writes DATA_IN[30:0] in any state, and DATA_IN[31] is ignored.
REQ-015 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL, in IDLE with START=1 and LEN!=0, load remaining=LEN and acc=0 and enter RUN; START with LEN=0 SHALL be ignored.
REQ-017 SHALL, on a same-cycle LEN_WE and START, use the LEN value held before the write.
REQ-018 SHALL drive SN_EN=1 on every RUN cycle and decrement remaining on each such cycle; SN_EN SHALL be 0 in all other states.
REQ-019 SHALL, in RUN when remaining==1, go to DRAIN on the next edge, so that SN_EN is high for exactly LEN cycles.
REQ-020 SHALL sample SN_IN_P/N one cycle after each SN_EN=1 cycle, using a delayed-enable flag; exactly LEN samples SHALL be taken, the last one in DRAIN.
REQ-021 SHALL, when MODE=0, perform acc += SN_IN_P per sample; the range is 0..LEN and no overflow is possible.
REQ-022 SHALL, when MODE=1, perform acc += +1 on P=1,N=0, -1 on P=0,N=1, and 0 otherwise; acc is 32-bit signed with range +/-LEN.
REQ-023 SHALL go from DRAIN to DONE on the next edge; in DONE, RES_VALID=1 and RES_OUT=acc, held stable until the handshake.
REQ-024 SHALL, in DONE with RES_READY=1 on an edge, go to IDLE and deassert RES_VALID on the next cycle; RES_OUT keeps its last value.
REQ-025 SHALL ignore START in RUN, DRAIN and DONE.
REQ-026 SHALL leave the in-flight run unaffected by LEN_WE during RUN, DRAIN or DONE, because remaining is loaded only at start.
REQ-027 SHALL allow RES_READY to be held high before DONE; DONE then lasts exactly one cycle.
REQ-028 SHALL make total latency from START to RES_VALID rise equal to LEN+2 cycles.

Reset
REQ-029 SHALL, while RST=1, set state=IDLE, LEN=0, remaining=0, acc=0, the delayed flag=0, SN_EN=0, BUSY=0, RES_VALID=0 and RES_OUT=0.
REQ-030 SHALL, on RST asserted mid-run, abort the run, drive SN_EN=0 from the next cycle, and produce no result.
REQ-031 SHALL, after RST is released, require a new LEN_WE before a START is accepted, since LEN=0.

Verification
REQ-032 Unipolar: MODE=0, LEN=16, SN_IN_P tied to 1 -> SN_EN high for 16 cycles, RES_VALID 18 cycles after START, RES_OUT=16.
REQ-033 Bipolar: MODE=1, LEN=8, P=1,N=0 on 6 samples and P=0,N=1 on 2 samples -> RES_OUT=4; all-negative pattern -> RES_OUT=32'hFFFF_FFF8.
REQ-034 Boundaries: LEN=0 with START -> stays IDLE, BUSY=0; LEN=1 -> one SN_EN cycle, RES_VALID 3 cycles after START.
REQ-035 Handshake: RES_READY held low 5 cycles in DONE -> RES_OUT stable and RES_VALID high throughout; START during DONE is ignored; READY high -> IDLE next cycle.
REQ-036 Collisions: LEN_WE(DATA_IN=5) in the same cycle as START with old LEN=3 -> 3 SN_EN cycles; LEN_WE during RUN -> current count unchanged, next run uses the new LEN.
REQ-037 Reset mid-run: RST at RUN cycle 4 of 10 -> SN_EN, BUSY and RES_VALID are 0 the next cycle, with no result emitted afterwards.
